// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding,
// default geometry of the memory interface and the index-width helper.
package mem_arbiter_pkg;

  localparam int unsigned MEM_LAT_DEF = 4;
  localparam int unsigned BURST_DEF   = 8;
  localparam int unsigned AW_DEF      = 16;
  localparam int unsigned DW_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } state_e;

  // Width of a word index inside one line fill.
  function automatic int unsigned idx_w(input int unsigned burst);
    return $clog2(burst);
  endfunction

endpackage

// File: rtl/mem_arbiter_burst_ctr.sv
// Loadable up-counter that stops at MAX and flags it (terminal count).
// Used for the issue, receive and write-wait counters of mem_arbiter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count -> 0)
//   load_i       load load_val_i (has priority over en_i)
//   load_val_i   value to load
//   en_i         count up by one; held at MAX once reached
//   cnt_o        current count
//   tc_o         count equals MAX
module mem_arbiter_burst_ctr #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == W'(MAX));
  assign cnt_o = cnt_q;

  // Next count: load wins, otherwise increment until terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined fixed-latency memory between the I-cache
// fill path and the D-cache fill/write path. Fills are BURST-word bursts
// issued one address per cycle; D writes are single words that occupy the
// memory for MEM_LAT cycles. Returned words are steered to the granted side.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (ties go to the side not granted last); default is fixed D-over-I priority.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req, i_addr              I-side line-fill request and line address
//   i_rvalid, i_idx, i_done    I-side returned word valid/index, completion
//   d_req, d_wr, d_addr,       D-side request, write select, address,
//   d_wdata                    write data
//   d_rvalid, d_idx, d_done    D-side returned word valid/index, completion
//   rdata                      returned word, common to both sides
//   mem_en, mem_wr, mem_addr,  memory command strobe, write qualifier,
//   mem_wdata                  byte address, write data
//   mem_rdata, mem_rvalid      memory read return
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter  int unsigned BURST   = BURST_DEF,
  parameter  int unsigned AW      = AW_DEF,
  parameter  int unsigned DW      = DW_DEF,
  localparam int unsigned IDX_W   = idx_w(BURST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_rvalid,
  output logic [IDX_W-1:0] i_idx,
  output logic             i_done,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [AW-1:0]    d_addr,
  input  logic [DW-1:0]    d_wdata,
  output logic             d_rvalid,
  output logic [IDX_W-1:0] d_idx,
  output logic             d_done,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_rvalid
);

  localparam int unsigned IC_W = IDX_W + 1;
  localparam int unsigned WT_W = $clog2(MEM_LAT) + 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             in_idle;
  logic             fill_act;
  logic             grant;
  logic             pick_d;
  logic [IC_W-1:0]  ic_cnt;
  logic             ic_tc;
  logic [IDX_W-1:0] rc_cnt;
  logic             rc_tc;
  logic [WT_W-1:0]  wt_cnt;
  logic             wt_tc;
  logic             unused_bits;

  assign in_idle  = (state_q == ST_IDLE);
  assign fill_act = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
  assign grant    = in_idle && (i_req || d_req);
  assign rdata    = mem_rdata;

  // Issue count MSB only marks saturation, which ic_tc already reports.
  assign unused_bits = ic_cnt[IDX_W];

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  // Tie goes to the side that did not win the previous grant.
  assign pick_d = d_req && (!i_req || !last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (grant) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  // Request payload captured at grant so requesters may drop mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      addr_q  <= pick_d ? d_addr : i_addr;
      wdata_q <= d_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters clear in IDLE, so every granted state starts from zero.
  mem_arbiter_burst_ctr #(.W(IC_W), .MAX(BURST)) u_ic (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (in_idle),
    .load_val_i ('0),
    .en_i       (fill_act),
    .cnt_o      (ic_cnt),
    .tc_o       (ic_tc)
  );

  mem_arbiter_burst_ctr #(.W(IDX_W), .MAX(BURST - 1)) u_rc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (in_idle),
    .load_val_i ('0),
    .en_i       (fill_act && mem_rvalid),
    .cnt_o      (rc_cnt),
    .tc_o       (rc_tc)
  );

  mem_arbiter_burst_ctr #(.W(WT_W), .MAX(MEM_LAT - 1)) u_wt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (in_idle),
    .load_val_i ('0),
    .en_i       (state_q == ST_D_WRITE),
    .cnt_o      (wt_cnt),
    .tc_o       (wt_tc)
  );

  // Next state, memory command and requester steering.
  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_rvalid  = 1'b0;
    i_idx     = '0;
    i_done    = 1'b0;
    d_rvalid  = 1'b0;
    d_idx     = '0;
    d_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          if (pick_d) begin
            state_d = d_wr ? ST_D_WRITE : ST_D_FILL;
          end else begin
            state_d = ST_I_FILL;
          end
        end
      end
      ST_I_FILL, ST_D_FILL: begin
        if (!ic_tc) begin
          mem_en   = 1'b1;
          mem_addr = {addr_q[AW-1:IDX_W+1], ic_cnt[IDX_W-1:0], 1'b0};
        end
        if (state_q == ST_I_FILL) begin
          i_rvalid = mem_rvalid;
          i_idx    = rc_cnt;
          i_done   = mem_rvalid && rc_tc;
        end else begin
          d_rvalid = mem_rvalid;
          d_idx    = rc_cnt;
          d_done   = mem_rvalid && rc_tc;
        end
        if (mem_rvalid && rc_tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_D_WRITE: begin
        if (wt_cnt == '0) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        if (wt_tc) begin
          d_done  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;
  localparam int IDX_W   = 3;
  localparam int NV      = 6;

  logic        clk;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_rvalid, i_done, d_rvalid, d_done;
  logic [2:0]  i_idx, d_idx;
  logic [15:0] rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rvalid   (i_rvalid),
    .i_idx      (i_idx),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rvalid   (d_rvalid),
    .d_idx      (d_idx),
    .d_done     (d_done),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Off-chip memory: fixed-latency read pipe, not reset by the arbiter reset.
  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  logic [MEM_LAT-1:0] rv_pipe = '0;
  logic [15:0]        ad_pipe [MEM_LAT] = '{default: 16'h0};

  always @(posedge clk) begin
    rv_pipe    <= {rv_pipe[MEM_LAT-2:0], mem_en & ~mem_wr};
    ad_pipe[0] <= mem_addr;
    for (int s = 1; s < MEM_LAT; s++) ad_pipe[s] <= ad_pipe[s-1];
  end

  assign mem_rvalid = rv_pipe[MEM_LAT-1];
  assign mem_rdata  = mem_rvalid ? mem_f(ad_pipe[MEM_LAT-1]) : 16'h0;

  typedef struct {
    string       name;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        exp_d;
    int          exp_lat, exp_nen, exp_nwr;
    logic [15:0] exp_a0, exp_alast, exp_wd;
    int          exp_irv, exp_drv;
  } vec_t;

  typedef struct {
    int          lat;
    logic        side_d;
    int          nen, nwr;
    logic [15:0] addr0, addr_last, wdata0;
    int          n_irv, n_drv;
    int          bad;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sync();
  endtask

  // Called in an IDLE cycle just after driving requests; follows one
  // transaction from its grant edge to the first done pulse.
  task automatic watch(input logic [15:0] base, input logic drop_done,
                       input int drop_at, output obs_t o);
    o.lat = -1; o.side_d = 1'b0; o.nen = 0; o.nwr = 0;
    o.addr0 = 16'h0; o.addr_last = 16'h0; o.wdata0 = 16'h0;
    o.n_irv = 0; o.n_drv = 0; o.bad = 0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (o.nen == 0) begin
          o.addr0  = mem_addr;
          o.wdata0 = mem_wdata;
        end
        o.addr_last = mem_addr;
        o.nen++;
        if (mem_wr) o.nwr++;
      end
      if (i_rvalid && d_rvalid) o.bad++;
      if (i_done && d_done) o.bad++;
      if (i_rvalid) begin
        if (i_idx != IDX_W'(o.n_irv) ||
            rdata != mem_f({base[15:4], IDX_W'(o.n_irv), 1'b0})) o.bad++;
        o.n_irv++;
      end
      if (d_rvalid) begin
        if (d_idx != IDX_W'(o.n_drv) ||
            rdata != mem_f({base[15:4], IDX_W'(o.n_drv), 1'b0})) o.bad++;
        o.n_drv++;
      end
      if (k == drop_at) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
      if (i_done || d_done) begin
        o.lat    = k;
        o.side_d = d_done;
        break;
      end
    end
    if (o.lat < 0) $display("FAIL watch_timeout: got no done expected done within 40 cycles");
    sync();
    if (drop_done && o.lat >= 0) begin
      if (o.side_d) d_req = 1'b0;
      else          i_req = 1'b0;
    end
  endtask

  task automatic quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (mem_en || i_rvalid || d_rvalid || i_done || d_done) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  function automatic logic [31:0] out_or();
    return 32'({mem_en, mem_wr, mem_addr != 16'h0, mem_wdata != 16'h0,
                i_rvalid, i_idx != 3'd0, i_done, d_rvalid, d_idx != 3'd0, d_done});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [NV];
    obs_t o;
    logic [3:0] exp6;
    logic       found;

    vecs[0] = '{"i_fill",      1'b1, 1'b0, 1'b0, 16'h0120, 16'h0000, 16'h0000,
                1'b0, 11, 8, 0, 16'h0120, 16'h012E, 16'h0000, 8, 0};
    vecs[1] = '{"d_fill",      1'b0, 1'b1, 1'b0, 16'h0000, 16'h4000, 16'h0000,
                1'b1, 11, 8, 0, 16'h4000, 16'h400E, 16'h0000, 0, 8};
    vecs[2] = '{"d_write",     1'b0, 1'b1, 1'b1, 16'h0000, 16'h0A06, 16'hBEEF,
                1'b1, 3, 1, 1, 16'h0A06, 16'h0A06, 16'hBEEF, 0, 0};
    vecs[3] = '{"i_fill_unal", 1'b1, 1'b0, 1'b0, 16'h1237, 16'h0000, 16'h0000,
                1'b0, 11, 8, 0, 16'h1230, 16'h123E, 16'h0000, 8, 0};
    vecs[4] = '{"d_fill_top",  1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFF5, 16'h0000,
                1'b1, 11, 8, 0, 16'hFFF0, 16'hFFFE, 16'h0000, 0, 8};
    vecs[5] = '{"d_write_odd", 1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0001,
                1'b1, 3, 1, 1, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0};

    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", out_or() | 32'(rdata), 32'd0);

    do_reset();

    for (int n = 0; n < NV; n++) begin
      i_req = vecs[n].i_req; d_req = vecs[n].d_req; d_wr = vecs[n].d_wr;
      i_addr = vecs[n].i_addr; d_addr = vecs[n].d_addr; d_wdata = vecs[n].d_wdata;
      watch(vecs[n].exp_d ? vecs[n].d_addr : vecs[n].i_addr, 1'b1, -1, o);
      i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
      chk($sformatf("%s_side", vecs[n].name), 32'(o.side_d), 32'(vecs[n].exp_d));
      chk($sformatf("%s_lat", vecs[n].name), 32'(o.lat), 32'(vecs[n].exp_lat));
      chk($sformatf("%s_nen", vecs[n].name), 32'(o.nen), 32'(vecs[n].exp_nen));
      chk($sformatf("%s_nwr", vecs[n].name), 32'(o.nwr), 32'(vecs[n].exp_nwr));
      chk($sformatf("%s_addr0", vecs[n].name), 32'(o.addr0), 32'(vecs[n].exp_a0));
      chk($sformatf("%s_alast", vecs[n].name), 32'(o.addr_last), 32'(vecs[n].exp_alast));
      chk($sformatf("%s_irv", vecs[n].name), 32'(o.n_irv), 32'(vecs[n].exp_irv));
      chk($sformatf("%s_drv", vecs[n].name), 32'(o.n_drv), 32'(vecs[n].exp_drv));
      chk($sformatf("%s_seq", vecs[n].name), 32'(o.bad), 32'd0);
      if (vecs[n].d_wr) chk($sformatf("%s_wdata", vecs[n].name), 32'(o.wdata0), 32'(vecs[n].exp_wd));
    end

    // Simultaneous requests: D first, I one IDLE cycle after d_done.
    do_reset();
    i_req = 1'b1; i_addr = 16'h0120; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h4000;
    watch(16'h4000, 1'b1, -1, o);
    chk("tie_first_side", 32'(o.side_d), 32'd1);
    chk("tie_first_lat", 32'(o.lat), 32'd11);
    watch(16'h0120, 1'b1, -1, o);
    chk("tie_second_side", 32'(o.side_d), 32'd0);
    chk("tie_second_lat", 32'(o.lat), 32'd11);
    chk("tie_second_seq", 32'(o.bad + (o.n_irv ^ 8)), 32'd0);

    // Reset mid I fill after word 3; stale returns must be dropped.
    do_reset();
    i_req = 1'b1; i_addr = 16'h2200;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (i_rvalid && i_idx == 3'd3) found = 1'b1;
    end
    chk("rst_word3_seen", 32'(found), 32'd1);
    rst_n = 1'b0; i_req = 1'b0;
    #1;
    chk("rst_outputs_zero", out_or(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet("rst_stale_dropped", 6);
    sync();
    i_req = 1'b1; i_addr = 16'h2200;
    watch(16'h2200, 1'b1, -1, o);
    chk("rst_refill_lat", 32'(o.lat), 32'd11);
    chk("rst_refill_nen", 32'(o.nen), 32'd8);
    chk("rst_refill_irv", 32'(o.n_irv), 32'd8);
    chk("rst_refill_seq", 32'(o.bad), 32'd0);

    // D request dropped mid-burst: burst completes, one done only.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h6010;
    watch(16'h6010, 1'b1, 2, o);
    chk("drop_side", 32'(o.side_d), 32'd1);
    chk("drop_lat", 32'(o.lat), 32'd11);
    chk("drop_nen", 32'(o.nen), 32'd8);
    chk("drop_drv", 32'(o.n_drv), 32'd8);
    quiet("drop_single_done", 6);

    // Continuous requests from both sides for four transactions.
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp6 = 4'b0101;
`else
    exp6 = 4'b1111;
`endif
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; i_addr = 16'h3000; d_addr = 16'h5000;
    for (int t = 0; t < 4; t++) begin
      watch(exp6[t] ? 16'h5000 : 16'h3000, 1'b0, -1, o);
      chk($sformatf("cont_side_%0d", t), 32'(o.side_d), 32'(exp6[t]));
      chk($sformatf("cont_lat_%0d", t), 32'(o.lat), 32'd11);
    end
    i_req = 1'b0; d_req = 1'b0;
    quiet("cont_idle_after", 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
